// File: rtl/cmp_req_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_req_pkg
//  Description : Shared types and constants for the comparator request
//                master: FSM state encoding, response result codes,
//                statistics counter width and the flag-to-code encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmp_req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] RES_EQ  = 2'b00;
    localparam logic [1:0] RES_LT  = 2'b01;
    localparam logic [1:0] RES_GT  = 2'b10;
    localparam logic [1:0] RES_ERR = 2'b11;

    localparam int STAT_W = 16;

    // Only a clean one-hot flag set is trusted; anything else is an error.
    function automatic logic [1:0] encode_flags(input logic gt,
                                                input logic lt,
                                                input logic eq);
        logic [1:0] code;
        case ({gt, lt, eq})
            3'b100:  code = RES_GT;
            3'b010:  code = RES_LT;
            3'b001:  code = RES_EQ;
            default: code = RES_ERR;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_req_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_req_master_if
//  Description : Bundles the request channel, the comparator start/done
//                interface and the response channel of the comparator
//                request master. "master" is the view of the request master
//                itself; "slave" is the view of its environment (host plus
//                comparator).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cmp_req_master_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [TAG_W-1:0]  req_tag;

    logic              cmp_start;
    logic [DATA_W-1:0] cmp_ain;
    logic [DATA_W-1:0] cmp_bin;
    logic              cmp_greater;
    logic              cmp_less;
    logic              cmp_equal;
    logic              cmp_done;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_code;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (
        input  req_valid, req_a, req_b, req_tag,
        input  cmp_greater, cmp_less, cmp_equal, cmp_done,
        input  rsp_ready,
        output req_ready, cmp_start, cmp_ain, cmp_bin,
        output rsp_valid, rsp_code, rsp_tag
    );

    modport slave (
        output req_valid, req_a, req_b, req_tag,
        output cmp_greater, cmp_less, cmp_equal, cmp_done,
        output rsp_ready,
        input  req_ready, cmp_start, cmp_ain, cmp_bin,
        input  rsp_valid, rsp_code, rsp_tag
    );

endinterface
`default_nettype wire

// File: rtl/cmp_req_master_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_sat_counter
//  Description : Saturating up-counter with synchronous clear. Clear wins
//                over an increment in the same cycle; the count sticks at
//                all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clr,
    input  wire logic             inc,
    output logic [WIDTH-1:0]      count
);

    // Count events, holding at the maximum value instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmp_req_master.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_req_master
//  Description : Initiator for the comparator start/done interface. Accepts
//                an operand pair plus tag, fires one start pulse, waits for
//                done (bounded by TIMEOUT cycles), encodes the result flags
//                into a 2-bit code and returns it with the tag.
//                Optional statistics counters are enabled by defining
//                CMP_REQ_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_req_master
    import cmp_req_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    cmp_req_master_if.master    bus,
    output logic                timeout_sticky
`ifdef CMP_REQ_STATS_EN
    ,
    input  wire logic           stat_clr,
    output logic [STAT_W-1:0]   stat_gt,
    output logic [STAT_W-1:0]   stat_lt,
    output logic [STAT_W-1:0]   stat_eq,
    output logic [STAT_W-1:0]   stat_err
`endif
);

    // TIMEOUT >= 2, so the counter is at least one bit wide.
    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              start;
    logic [DATA_W-1:0] ain;
    logic [DATA_W-1:0] bin;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        code;
    logic              sticky;

    logic              accept;
    logic              wait_done;
    logic              wait_expired;
    logic              wait_exit;
    logic [1:0]        code_nx;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and the decoded events that drive the datapath.
    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        wait_done    = 1'b0;
        wait_expired = 1'b0;
        code_nx      = RES_ERR;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept   = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                // Done takes priority over an expiring counter.
                if (bus.cmp_done) begin
                    wait_done = 1'b1;
                    code_nx   = encode_flags(bus.cmp_greater, bus.cmp_less,
                                             bus.cmp_equal);
                    state_nx  = ST_RESP;
                end else if (cnt == CNT_LAST) begin
                    wait_expired = 1'b1;
                    state_nx     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign wait_exit = wait_done | wait_expired;

    // Datapath: operand/tag capture, start pulse, wait counter, result code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start  <= 1'b0;
            ain    <= '0;
            bin    <= '0;
            tag    <= '0;
            cnt    <= '0;
            code   <= RES_EQ;
            sticky <= 1'b0;
        end else begin
            // High only in the ISSUE cycle that follows acceptance.
            start <= accept;
            if (accept) begin
                ain <= bus.req_a;
                bin <= bus.req_b;
                tag <= bus.req_tag;
            end
            if (state == ST_ISSUE) begin
                cnt <= '0;
            end else if ((state == ST_WAIT) && !wait_exit) begin
                cnt <= cnt + 1'b1;
            end
            if (wait_exit) begin
                code <= code_nx;
            end
            if (wait_expired) begin
                sticky <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.rsp_valid  = (state == ST_RESP);
    assign bus.cmp_start  = start;
    assign bus.cmp_ain    = ain;
    assign bus.cmp_bin    = bin;
    assign bus.rsp_code   = code;
    assign bus.rsp_tag    = tag;
    assign timeout_sticky = sticky;

`ifdef CMP_REQ_STATS_EN
    // One increment per RESP entry, steered by the code being latched.
    logic inc_gt;
    logic inc_lt;
    logic inc_eq;
    logic inc_err;

    assign inc_gt  = wait_exit && (code_nx == RES_GT);
    assign inc_lt  = wait_exit && (code_nx == RES_LT);
    assign inc_eq  = wait_exit && (code_nx == RES_EQ);
    assign inc_err = wait_exit && (code_nx == RES_ERR);

    cmp_sat_counter #(.WIDTH(STAT_W)) u_stat_gt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (inc_gt),
        .count (stat_gt)
    );

    cmp_sat_counter #(.WIDTH(STAT_W)) u_stat_lt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (inc_lt),
        .count (stat_lt)
    );

    cmp_sat_counter #(.WIDTH(STAT_W)) u_stat_eq (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (inc_eq),
        .count (stat_eq)
    );

    cmp_sat_counter #(.WIDTH(STAT_W)) u_stat_err (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (inc_err),
        .count (stat_err)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmp_req_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_req_master
//  Description : Directed self-checking bench for cmp_req_master with a
//                small comparator model (normal, never-done, bad-flags).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_req_master;
    import cmp_req_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic timeout_sticky;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   n_start = 0;
    int   mode    = 0;   // 0 normal, 1 never done, 2 greater+less
    int   lat;
    int   base;

`ifdef CMP_REQ_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_gt;
    logic [15:0] stat_lt;
    logic [15:0] stat_eq;
    logic [15:0] stat_err;
`endif

    always #5 clk = ~clk;

    cmp_req_master_if #(.DATA_W(16), .TAG_W(4)) bus ();

    cmp_req_master #(.DATA_W(16), .TAG_W(4), .TIMEOUT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .timeout_sticky (timeout_sticky)
`ifdef CMP_REQ_STATS_EN
        ,
        .stat_clr       (stat_clr),
        .stat_gt        (stat_gt),
        .stat_lt        (stat_lt),
        .stat_eq        (stat_eq),
        .stat_err       (stat_err)
`endif
    );

    // Comparator model: answers one cycle after it samples start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cmp_done    <= 1'b0;
            bus.cmp_greater <= 1'b0;
            bus.cmp_less    <= 1'b0;
            bus.cmp_equal   <= 1'b0;
        end else if (bus.cmp_start && mode != 1) begin
            bus.cmp_done <= 1'b1;
            if (mode == 2) begin
                bus.cmp_greater <= 1'b1;
                bus.cmp_less    <= 1'b1;
                bus.cmp_equal   <= 1'b0;
            end else begin
                bus.cmp_greater <= (bus.cmp_ain > bus.cmp_bin);
                bus.cmp_less    <= (bus.cmp_ain < bus.cmp_bin);
                bus.cmp_equal   <= (bus.cmp_ain == bus.cmp_bin);
            end
        end else begin
            bus.cmp_done    <= 1'b0;
            bus.cmp_greater <= 1'b0;
            bus.cmp_less    <= 1'b0;
            bus.cmp_equal   <= 1'b0;
        end
    end

    // Count start pulses as seen by the comparator.
    always @(posedge clk) begin
        if (bus.cmp_start) n_start++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in an IDLE cycle; returns one step after acceptance.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = t;
        bus.req_valid = 1'b1;
        tick();
        chk("accept_start", bus.cmp_start, 1);
        bus.req_valid = 1'b0;
    endtask

    // Edges from acceptance until rsp_valid is seen, bounded.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("rsp_arrived", bus.rsp_valid, 1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) tick();

        // Reset values
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_cmp_start", bus.cmp_start, 0);
        chk("rst_cmp_ain",   bus.cmp_ain, 0);
        chk("rst_cmp_bin",   bus.cmp_bin, 0);
        chk("rst_rsp_code",  bus.rsp_code, 0);
        chk("rst_rsp_tag",   bus.rsp_tag, 0);
        chk("rst_sticky",    timeout_sticky, 0);
`ifdef CMP_REQ_STATS_EN
        chk("rst_stat_gt",  stat_gt, 0);
        chk("rst_stat_err", stat_err, 0);
`endif
        rst_n = 1'b1;
        tick();

        // GT with nominal cycle-by-cycle timing
        base = n_start;
        send(16'h1234, 16'h00FF, 4'd3);
        chk("gt_ain", bus.cmp_ain, 32'h1234);
        chk("gt_bin", bus.cmp_bin, 32'h00FF);
        chk("gt_ready_busy", bus.req_ready, 0);
        tick();
        chk("gt_start_e1", bus.cmp_start, 0);
        chk("gt_valid_e1", bus.rsp_valid, 0);
        tick();
        chk("gt_valid_e2", bus.rsp_valid, 1);
        chk("gt_code", bus.rsp_code, 2'b10);
        chk("gt_tag", bus.rsp_tag, 3);
        chk("gt_one_start", n_start - base, 1);
        tick();
        chk("gt_valid_done", bus.rsp_valid, 0);
        chk("gt_ready_back", bus.req_ready, 1);

        // EQ on all-ones, then LT back-to-back
        send(16'hFFFF, 16'hFFFF, 4'd7);
        wait_rsp(lat);
        chk("eq_latency", lat, 2);
        chk("eq_code", bus.rsp_code, 2'b00);
        chk("eq_tag", bus.rsp_tag, 7);
        chk("eq_ready_low", bus.req_ready, 0);
        tick();
        chk("b2b_ready", bus.req_ready, 1);
        send(16'h0000, 16'h8000, 4'd9);
        chk("lt_ready_low", bus.req_ready, 0);
        wait_rsp(lat);
        chk("lt_latency", lat, 2);
        chk("lt_code", bus.rsp_code, 2'b01);
        chk("lt_tag", bus.rsp_tag, 9);
        tick();

        // Bad flag combination with done
        mode = 2;
        send(16'h0005, 16'h0005, 4'd2);
        wait_rsp(lat);
        chk("bad_code", bus.rsp_code, 2'b11);
        chk("bad_tag", bus.rsp_tag, 2);
        chk("bad_sticky", timeout_sticky, 0);
        tick();

        // Timeout: 8 WAIT cycles after ISSUE
        mode = 1;
        send(16'h0001, 16'h0002, 4'd4);
        wait_rsp(lat);
        chk("to_latency", lat, 9);
        chk("to_code", bus.rsp_code, 2'b11);
        chk("to_tag", bus.rsp_tag, 4);
        chk("to_sticky", timeout_sticky, 1);
        tick();
        mode = 0;
        send(16'h0002, 16'h0001, 4'd5);
        wait_rsp(lat);
        chk("post_to_latency", lat, 2);
        chk("post_to_code", bus.rsp_code, 2'b10);
        chk("post_to_sticky", timeout_sticky, 1);
        tick();

        // Backpressure for 20 cycles with a competing request present
        bus.rsp_ready = 1'b0;
        send(16'h0010, 16'h0020, 4'd6);
        wait_rsp(lat);
        base = n_start;
        bus.req_a     = 16'hAAAA;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_code", bus.rsp_code, 2'b01);
            chk("bp_tag", bus.rsp_tag, 6);
            chk("bp_ready", bus.req_ready, 0);
            chk("bp_no_start", n_start - base, 0);
            chk("bp_ain", bus.cmp_ain, 32'h0010);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_release", bus.rsp_valid, 0);

        // Reset while waiting for done
        mode = 1;
        send(16'h0003, 16'h0003, 4'd1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_req_ready", bus.req_ready, 1);
        chk("mrst_rsp_valid", bus.rsp_valid, 0);
        chk("mrst_cmp_start", bus.cmp_start, 0);
        chk("mrst_cmp_ain",   bus.cmp_ain, 0);
        chk("mrst_cmp_bin",   bus.cmp_bin, 0);
        chk("mrst_rsp_code",  bus.rsp_code, 0);
        chk("mrst_rsp_tag",   bus.rsp_tag, 0);
        chk("mrst_sticky",    timeout_sticky, 0);
        mode = 0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("mrst_no_rsp", bus.rsp_valid, 0);
        send(16'h8000, 16'h7FFF, 4'hA);
        wait_rsp(lat);
        chk("mrst_latency", lat, 2);
        chk("mrst_code", bus.rsp_code, 2'b10);
        chk("mrst_tag", bus.rsp_tag, 4'hA);
        tick();

`ifdef CMP_REQ_STATS_EN
        // Two more GT and one ERR on top of the GT above
        send(16'h0009, 16'h0008, 4'd1);
        wait_rsp(lat);
        tick();
        send(16'hFFFF, 16'h0000, 4'd2);
        wait_rsp(lat);
        tick();
        mode = 2;
        send(16'h0001, 16'h0001, 4'd3);
        wait_rsp(lat);
        tick();
        mode = 0;
        chk("stat_gt", stat_gt, 3);
        chk("stat_lt", stat_lt, 0);
        chk("stat_eq", stat_eq, 0);
        chk("stat_err", stat_err, 1);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr_gt", stat_gt, 0);
        chk("clr_lt", stat_lt, 0);
        chk("clr_eq", stat_eq, 0);
        chk("clr_err", stat_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmp_req_master.md
Name: cmp_req_master

Overview:
- Initiator for the 16-bit comparator start/done interface.
- Accepts operand pairs on a valid/ready request channel and drives one single-cycle start pulse per pair.
- Waits for done, encodes greater/less/equal into a 2-bit result code, and returns it with the request tag on a valid/ready response channel.
- Bounds each wait with a timeout. Sits between a host/CSR or datapath requester and the comparator instance.

Parameters:
- DATA_W, 16, operand width (matches the comparator ain/bin).
- TAG_W, 4, width of the opaque request tag echoed on the response.
- TIMEOUT, 8, cycles to wait for cmp_done before reporting an error; legal range ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_a  in  DATA_W  operand A
- req_b  in  DATA_W  operand B
- req_tag  in  TAG_W  request tag
- cmp_start  out  1  comparator start pulse, registered
- cmp_ain  out  DATA_W  comparator operand A, registered
- cmp_bin  out  DATA_W  comparator operand B, registered
- cmp_greater  in  1  comparator result flag
- cmp_less  in  1  comparator result flag
- cmp_equal  in  1  comparator result flag
- cmp_done  in  1  comparator done
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_code  out  2  result: 00=EQ, 01=LT, 10=GT, 11=ERR
- rsp_tag  out  TAG_W  echoed tag
- timeout_sticky  out  1  set on any timeout; cleared only by reset

Behaviour:
- Reset values: all outputs 0 except req_ready, which is 1 (state IDLE); timeout counter 0. Reset mid-transaction abandons the transaction with no response.
- FSM states IDLE, ISSUE, WAIT, RESP. req_ready = (state==IDLE); rsp_valid = (state==RESP).
- IDLE: on req_valid, capture req_a/req_b/req_tag into cmp_ain/cmp_bin/rsp_tag and set cmp_start. Next state ISSUE.
- ISSUE: cmp_start is high for exactly this one cycle, then cleared. Counter cleared. Next state WAIT.
- WAIT:
  - If cmp_done: latch the flags. Exactly-one-hot flags map to the code; any other combination gives ERR. Next state RESP.
  - Else, if counter==TIMEOUT-1: code ERR, set timeout_sticky, go to RESP. Otherwise increment the counter.
- RESP: hold rsp_code/rsp_tag stable until rsp_ready; on handshake go to IDLE. Backpressure has no cycle limit.
- Nominal latency: acceptance edge E0 → cmp_start sampled at E1 → cmp_done sampled at E2 → rsp_valid high from E2. Minimum 4 cycles per transaction; one transaction outstanding.
- cmp_ain/cmp_bin hold their values from capture until the next capture.
- cmp_done outside WAIT is ignored; done and timeout in the same cycle resolve in favour of done.
- Operands are unsigned, compared at full DATA_W; the block itself does no arithmetic.

Optional Feature:
- Macro CMP_REQ_STATS_EN.
- With the macro: adds stat_clr (in, 1) and stat_gt/stat_lt/stat_eq/stat_err (out, 16 each). These are saturating counters incremented on each RESP entry by code. stat_clr synchronously zeroes all four; clear has priority over an increment in the same cycle. Reset value 0.
- Without the macro: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package cmp_req_pkg holds:
  - the state enum typedef;
  - result code localparams RES_EQ/RES_LT/RES_GT/RES_ERR;
  - the stat counter width constant.
- Sub-module cmp_sat_counter (16-bit saturating counter with inc/clr) is instantiated four times under CMP_REQ_STATS_EN.

Test Plan:
- a=0x1234, b=0x00FF, tag=3, rsp_ready=1 → exactly one cmp_start pulse; rsp_code=10, rsp_tag=3, rsp_valid at E2.
- a=b=0xFFFF, tag=7 → rsp_code=00; then a=0x0000, b=0x8000 back-to-back → rsp_code=01, req_ready low between acceptances.
- Comparator model never asserts done, TIMEOUT=8 → rsp_code=11 after 8 WAIT cycles; timeout_sticky=1 and stays 1 across the next good transaction.
- Model returns greater=less=1 with done → rsp_code=11, timeout_sticky stays 0.
- rsp_ready held low 20 cycles → rsp_valid/code/tag stable; req_ready stays 0; no further cmp_start.
- rst_n asserted during WAIT → all outputs return to reset values; the next request completes normally. With CMP_REQ_STATS_EN: 3 GT + 1 ERR gives stat_gt=3, stat_err=1; stat_clr zeroes all four.
